// File: rtl/firc_sched.sv
// Tap scheduler for the 29-tap symmetric complex FIR: three-phase issue of tap-pair addresses
// plus a LAT-deep phase pipe that drives accumulator clear/enable and output push.
module firc_sched #(
  parameter int unsigned LAT = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        FifoEmpty,
  output logic        FifoRd,
  output logic        ShiftEn,
  output logic        PhaseValid,
  output logic [1:0]  Phase,
  output logic [24:0] LocA,
  output logic [24:0] LocB,
  output logic [3:0]  CoefBase,
  output logic        Lane4Zero,
  output logic        AccClr,
  output logic        AccEn,
  output logic        PushOut,
  output logic        Busy
);

  typedef enum logic [1:0] {StIdle, StP0, StP1, StP2} state_e;

  state_e           state_q, state_d;
  logic [LAT-1:0]   pipe_v_q;
  logic [1:0]       pipe_p_q [LAT];
  logic             push_q;
  logic             issue_v;
  logic [1:0]       issue_p;
  logic             pop;

  // A new sample may only be accepted once the previous one has issued all three phases.
  assign pop = !FifoEmpty && (state_q == StIdle || state_q == StP2) && !Reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = FifoEmpty ? StIdle : StP0;
      StP0:    state_d = StP1;
      StP1:    state_d = StP2;
      StP2:    state_d = FifoEmpty ? StIdle : StP0;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue_v = 1'b0;
    issue_p = 2'd0;
    unique case (state_q)
      StP0:    begin issue_v = 1'b1; issue_p = 2'd0; end
      StP1:    begin issue_v = 1'b1; issue_p = 2'd1; end
      StP2:    begin issue_v = 1'b1; issue_p = 2'd2; end
      default: begin issue_v = 1'b0; issue_p = 2'd0; end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      pipe_v_q <= '0;
      push_q   <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe_p_q[i] <= 2'd0;
    end else begin
      state_q     <= state_d;
      pipe_v_q[0] <= issue_v;
      pipe_p_q[0] <= issue_p;
      for (int i = 1; i < LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_p_q[i] <= pipe_p_q[i-1];
      end
      push_q <= pipe_v_q[LAT-1] && (pipe_p_q[LAT-1] == 2'd2);
    end
  end

  // Every output is held low while Reset is asserted, including the first reset cycle.
  always_comb begin
    FifoRd     = pop;
    ShiftEn    = pop;
    PhaseValid = 1'b0;
    Phase      = 2'd0;
    LocA       = '0;
    LocB       = '0;
    CoefBase   = 4'd0;
    Lane4Zero  = 1'b0;
    AccEn      = 1'b0;
    AccClr     = 1'b0;
    PushOut    = 1'b0;
    Busy       = 1'b0;
    if (!Reset) begin
      PhaseValid = issue_v;
      Phase      = issue_p;
      if (issue_v) begin
        CoefBase  = 4'(5 * int'(issue_p));
        Lane4Zero = (issue_p == 2'd2);
        for (int k = 0; k < 5; k++) begin
          LocA[5*k +: 5] = 5'(5 * int'(issue_p) + k);
          LocB[5*k +: 5] = 5'(28 - 5 * int'(issue_p) - k);
        end
      end
      AccEn   = pipe_v_q[LAT-1];
      AccClr  = pipe_v_q[LAT-1] && (pipe_p_q[LAT-1] == 2'd0);
      PushOut = push_q;
      Busy    = (state_q != StIdle) || (|pipe_v_q);
    end
  end

endmodule
